// File: rtl/sram_arbiter_if.sv
// sram_arbiter_if: cache request/response, loader and SRAM wrapper signals around the arbiter
interface sram_arbiter_if #(
  parameter int ADDR_W = 20,
  parameter int LINE_W = 128
);
  logic              ic_req_valid;
  logic [ADDR_W-1:0] ic_req_addr;
  logic              ic_resp_valid;
  logic [LINE_W-1:0] ic_resp_data;
  logic              dc_req_valid;
  logic              dc_req_we;
  logic [ADDR_W-1:0] dc_req_addr;
  logic [LINE_W-1:0] dc_req_wdata;
  logic              dc_resp_valid;
  logic [LINE_W-1:0] dc_resp_data;
  logic              is_loading_memory_into_core;
  logic              mem_requested;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [LINE_W-1:0] mem_wr_data;
  logic              mem_reset_req;
  logic              mem_ready;
  logic [LINE_W-1:0] mem_rd_data;
  logic              busy;
  logic              owner;
  modport master (
    input  ic_req_valid, ic_req_addr, dc_req_valid, dc_req_we, dc_req_addr, dc_req_wdata,
           is_loading_memory_into_core, mem_ready, mem_rd_data,
    output ic_resp_valid, ic_resp_data, dc_resp_valid, dc_resp_data,
           mem_requested, mem_we, mem_addr, mem_wr_data, mem_reset_req, busy, owner
  );
  modport slave (
    output ic_req_valid, ic_req_addr, dc_req_valid, dc_req_we, dc_req_addr, dc_req_wdata,
           is_loading_memory_into_core, mem_ready, mem_rd_data,
    input  ic_resp_valid, ic_resp_data, dc_resp_valid, dc_resp_data,
           mem_requested, mem_we, mem_addr, mem_wr_data, mem_reset_req, busy, owner
  );
endinterface

// File: rtl/sram_arbiter.sv
// sram_arbiter: round-robin sharing of the SRAM wrapper port between icache and dcache miss paths
module sram_arbiter #(
  parameter int ADDR_W = 20,
  parameter int LINE_W = 128
) (
  input logic          clk,
  input logic          reset,
  sram_arbiter_if.master bus
);
  typedef enum logic [2:0] {IDLE, LAUNCH, WAIT, CAPTURE, RESP} state_t;
  state_t            r_state;
  logic              r_owner;
  logic              r_last_owner;
  logic              r_we;
  logic [ADDR_W-1:0] r_addr;
  logic [LINE_W-1:0] r_wdata;
  logic [LINE_W-1:0] r_ic_data;
  logic [LINE_W-1:0] r_dc_data;
  logic              w_busy;
  logic              w_owner_valid;
  logic              w_abort;
  logic              w_grant;
  logic              w_pick_dc;
  assign w_busy        = r_state != IDLE;
  assign w_owner_valid = r_owner ? bus.dc_req_valid : bus.ic_req_valid;
  assign w_abort       = (r_state == LAUNCH || r_state == WAIT) && !w_owner_valid;
  assign w_grant       = r_state == IDLE && !bus.is_loading_memory_into_core && bus.mem_ready &&
                         (bus.ic_req_valid || bus.dc_req_valid);
  assign w_pick_dc     = bus.dc_req_valid && (!bus.ic_req_valid || !r_last_owner);
  // requested drops the same cycle ready returns so the wrapper never sees a restart
  assign bus.mem_requested = !w_abort && (r_state == LAUNCH || (r_state == WAIT && !bus.mem_ready));
  assign bus.mem_reset_req = w_abort;
  assign bus.mem_we        = w_busy && r_we;
  assign bus.mem_addr      = w_busy ? r_addr : '0;
  assign bus.mem_wr_data   = w_busy ? r_wdata : '0;
  assign bus.ic_resp_valid = r_state == RESP && !r_owner;
  assign bus.dc_resp_valid = r_state == RESP && r_owner;
  assign bus.ic_resp_data  = r_ic_data;
  assign bus.dc_resp_data  = r_dc_data;
  assign bus.busy          = w_busy;
  assign bus.owner         = r_owner;
  // grant, launch, wait for the wrapper, capture the line, pulse the owner's response
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= IDLE;
      r_owner      <= 1'b0;
      r_last_owner <= 1'b0;
      r_we         <= 1'b0;
      r_addr       <= '0;
      r_wdata      <= '0;
      r_ic_data    <= '0;
      r_dc_data    <= '0;
    end else begin
      case (r_state)
        IDLE: if (w_grant) begin
          r_state      <= LAUNCH;
          r_owner      <= w_pick_dc;
          r_last_owner <= w_pick_dc;
          r_we         <= w_pick_dc && bus.dc_req_we;
          r_addr       <= w_pick_dc ? bus.dc_req_addr : bus.ic_req_addr;
          r_wdata      <= w_pick_dc ? bus.dc_req_wdata : '0;
        end
        LAUNCH: r_state <= w_abort ? IDLE : bus.mem_ready ? WAIT : LAUNCH;
        WAIT: r_state <= w_abort ? IDLE : bus.mem_ready ? CAPTURE : WAIT;
        CAPTURE: begin
          r_state <= RESP;
          if (r_owner) r_dc_data <= bus.mem_rd_data;
          else r_ic_data <= bus.mem_rd_data;
        end
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_sram_arbiter.sv
// tb_sram_arbiter: directed and randomized checks of sram_arbiter against a line-level model and a wrapper model
module tb_sram_arbiter;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int checks = 0;
  int failures = 0;
  int lat = 4;
  int starts = 0;
  logic exp_last = 1'b0;
  logic [127:0] ref_mem [logic [19:0]];
  logic [31:0] sram [0:1023];
  logic sr_busy;
  logic sr_we;
  int sr_idx;
  int sr_lat;
  int sr_a;
  logic [127:0] sr_data;

  sram_arbiter_if #(.ADDR_W(20), .LINE_W(128)) bus ();
  sram_arbiter #(.ADDR_W(20), .LINE_W(128)) dut (.clk(clk), .reset(reset), .bus(bus));

  always #5 clk = ~clk;

  function automatic logic [31:0] pat(input int i);
    return (i >> 2) == 16 ? 32'h11111111 * (i & 3) : (i * 32'h01000193) ^ 32'h5A5A0000;
  endfunction

  function automatic logic [127:0] model_read(input logic [19:0] a);
    int b;
    b = int'(a);
    return ref_mem.exists(a) ? ref_mem[a] : {pat(b + 3), pat(b + 2), pat(b + 1), pat(b)};
  endfunction

  function automatic logic winner(input logic iv, input logic dv);
    return (iv && dv) ? !exp_last : dv;
  endfunction

  assign bus.mem_ready = !sr_busy;

  // wrapper model: one countdown per accepted request, one word written per cycle, line read at the end
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      sr_busy <= 1'b0;
      sr_idx <= 0;
      bus.mem_rd_data <= '0;
      for (int i = 0; i < 1024; i++) sram[i] <= pat(i);
    end else if (bus.mem_reset_req) begin
      sr_busy <= 1'b0;
    end else if (!sr_busy && bus.mem_requested) begin
      sr_busy <= 1'b1;
      sr_idx <= 0;
      sr_lat <= lat;
      sr_we <= bus.mem_we;
      sr_a <= int'(bus.mem_addr);
      sr_data <= bus.mem_wr_data;
      starts <= starts + 1;
    end else if (sr_busy) begin
      if (sr_we && sr_idx < 4) sram[sr_a + sr_idx] <= sr_data[sr_idx*32 +: 32];
      sr_idx <= sr_idx + 1;
      if (sr_idx == sr_lat - 1) begin
        sr_busy <= 1'b0;
        if (!sr_we) bus.mem_rd_data <= {sram[sr_a+3], sram[sr_a+2], sram[sr_a+1], sram[sr_a]};
      end
    end
  end

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_launch();
    int n;
    n = 0;
    while (!bus.mem_requested && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("launch_seen", n < 50, 1'b1);
  endtask

  task automatic serve(input logic o, input logic we, input logic [19:0] a, input logic [127:0] wd);
    int n;
    int s0;
    logic ok;
    wait_launch();
    s0 = starts;
    chk("owner", bus.owner, o);
    chk("mem_we", bus.mem_we, we);
    chk("mem_addr", bus.mem_addr, a);
    if (we) chk("mem_wr_data", bus.mem_wr_data, wd);
    ok = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
      if (!bus.mem_ready) ok = ok & bus.mem_requested & (bus.mem_we == we);
    end while (!bus.mem_ready && n < 50);
    chk("req_held", ok, 1'b1);
    chk("req_drop_at_ready", bus.mem_requested, 1'b0);
    @(negedge clk);
    chk("capture_quiet", bus.ic_resp_valid | bus.dc_resp_valid, 1'b0);
    @(negedge clk);
    chk("resp_valid", o ? bus.dc_resp_valid : bus.ic_resp_valid, 1'b1);
    chk("other_quiet", o ? bus.ic_resp_valid : bus.dc_resp_valid, 1'b0);
    if (!we) chk("resp_data", o ? bus.dc_resp_data : bus.ic_resp_data, model_read(a));
    if (we) ref_mem[a] = wd;
    exp_last = o;
    if (o) bus.dc_req_valid = 1'b0;
    else bus.ic_req_valid = 1'b0;
    @(negedge clk);
    chk("pulse_once", bus.ic_resp_valid | bus.dc_resp_valid, 1'b0);
    chk("one_countdown", 128'(starts - s0), 1);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    ref_mem.delete();
    exp_last = 1'b0;
    bus.ic_req_valid = 1'b0;
    bus.dc_req_valid = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    logic ok;
    logic o;
    logic iv;
    logic dv;
    logic dwe;
    int kind;
    logic [19:0] ia;
    logic [19:0] da;
    logic [127:0] wd;
    bus.ic_req_valid = 1'b0;
    bus.ic_req_addr = '0;
    bus.dc_req_valid = 1'b0;
    bus.dc_req_we = 1'b0;
    bus.dc_req_addr = '0;
    bus.dc_req_wdata = '0;
    bus.is_loading_memory_into_core = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_busy", bus.busy, 1'b0);
    chk("rst_requested", bus.mem_requested, 1'b0);
    chk("rst_outputs", {bus.mem_we, bus.mem_reset_req, bus.owner, bus.ic_resp_valid, bus.dc_resp_valid, bus.mem_addr}, '0);
    chk("rst_wr_data", bus.mem_wr_data, '0);
    chk("rst_ic_data", bus.ic_resp_data, '0);
    chk("rst_dc_data", bus.dc_resp_data, '0);
    reset = 1'b0;
    @(negedge clk);
    chk("idle_after_reset", bus.busy, 1'b0);

    lat = 5;
    bus.ic_req_valid = 1'b1;
    bus.ic_req_addr = 20'h00040;
    serve(winner(1'b1, 1'b0), 1'b0, 20'h00040, '0);
    chk("ic_line_40", bus.ic_resp_data, 128'h33333333_22222222_11111111_00000000);

    wd = 128'hDDDDDDDD_CCCCCCCC_BBBBBBBB_AAAAAAAA;
    bus.dc_req_valid = 1'b1;
    bus.dc_req_we = 1'b1;
    bus.dc_req_addr = 20'h00100;
    bus.dc_req_wdata = wd;
    serve(winner(1'b0, 1'b1), 1'b1, 20'h00100, wd);
    chk("wb_word0", sram[256], 32'hAAAAAAAA);
    chk("wb_word1", sram[257], 32'hBBBBBBBB);
    chk("wb_word2", sram[258], 32'hCCCCCCCC);
    chk("wb_word3", sram[259], 32'hDDDDDDDD);
    bus.dc_req_valid = 1'b1;
    bus.dc_req_we = 1'b0;
    serve(winner(1'b0, 1'b1), 1'b0, 20'h00100, '0);
    chk("wb_readback", bus.dc_resp_data, wd);

    do_reset();
    lat = 4;
    bus.ic_req_valid = 1'b1;
    bus.ic_req_addr = 20'h00040;
    bus.dc_req_valid = 1'b1;
    bus.dc_req_addr = 20'h00080;
    o = winner(1'b1, 1'b1);
    chk("fair_first_dc", o, 1'b1);
    serve(o, 1'b0, o ? 20'h00080 : 20'h00040, '0);
    o = winner(1'b1, 1'b0);
    serve(o, 1'b0, 20'h00040, '0);

    for (int k = 0; k < 24; k++) begin
      kind = $urandom_range(0, 3);
      lat = $urandom_range(4, 9);
      ia = 20'($urandom_range(0, 255) * 4);
      da = 20'($urandom_range(0, 255) * 4);
      dwe = 1'($urandom_range(0, 1));
      wd = {$urandom, $urandom, $urandom, $urandom};
      iv = kind != 1;
      dv = kind != 0;
      bus.ic_req_valid = iv;
      bus.ic_req_addr = ia;
      bus.dc_req_valid = dv;
      bus.dc_req_we = dwe;
      bus.dc_req_addr = da;
      bus.dc_req_wdata = wd;
      o = winner(iv, dv);
      if (o) serve(1'b1, dwe, da, wd);
      else serve(1'b0, 1'b0, ia, '0);
      if (iv && dv) begin
        if (o) serve(1'b0, 1'b0, ia, '0);
        else serve(1'b1, dwe, da, wd);
      end
    end

    lat = 8;
    bus.dc_req_valid = 1'b1;
    bus.dc_req_we = 1'b0;
    bus.dc_req_addr = 20'h00200;
    wait_launch();
    exp_last = 1'b1;
    repeat (2) @(negedge clk);
    bus.dc_req_valid = 1'b0;
    #1;
    chk("abort_pulse", bus.mem_reset_req, 1'b1);
    chk("abort_req_low", bus.mem_requested, 1'b0);
    @(negedge clk);
    chk("abort_pulse_once", bus.mem_reset_req, 1'b0);
    chk("abort_ready", bus.mem_ready, 1'b1);
    chk("abort_idle", bus.busy, 1'b0);
    ok = 1'b0;
    repeat (4) begin
      @(negedge clk);
      ok = ok | bus.dc_resp_valid;
    end
    chk("abort_no_resp", ok, 1'b0);

    lat = 4;
    bus.ic_req_valid = 1'b1;
    bus.ic_req_addr = 20'h00140;
    bus.dc_req_valid = 1'b1;
    bus.dc_req_addr = 20'h00180;
    o = winner(1'b1, 1'b1);
    chk("fair_after_abort_ic", o, 1'b0);
    serve(o, 1'b0, o ? 20'h00180 : 20'h00140, '0);
    serve(!o, 1'b0, o ? 20'h00140 : 20'h00180, '0);

    bus.is_loading_memory_into_core = 1'b1;
    bus.ic_req_valid = 1'b1;
    bus.ic_req_addr = 20'h00080;
    ok = 1'b1;
    repeat (6) begin
      @(negedge clk);
      ok = ok & !bus.busy;
    end
    chk("loader_blocks", ok, 1'b1);
    bus.is_loading_memory_into_core = 1'b0;
    @(negedge clk);
    chk("loader_grant_next", bus.busy, 1'b1);
    serve(winner(1'b1, 1'b0), 1'b0, 20'h00080, '0);

    lat = 8;
    bus.ic_req_valid = 1'b1;
    bus.ic_req_addr = 20'h000C0;
    wait_launch();
    @(negedge clk);
    #2;
    reset = 1'b1;
    #1;
    chk("areset_busy", bus.busy, 1'b0);
    chk("areset_requested", bus.mem_requested, 1'b0);
    chk("areset_outputs", {bus.mem_we, bus.mem_reset_req, bus.owner, bus.ic_resp_valid, bus.dc_resp_valid, bus.mem_addr}, '0);
    chk("areset_ic_data", bus.ic_resp_data, '0);
    chk("areset_dc_data", bus.dc_resp_data, '0);
    bus.ic_req_valid = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("areset_stays_idle", bus.busy, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/sram_arbiter.md
Name: sram_arbiter

Overview:
- Shares the single SRAM wrapper port between the instruction-cache miss path and the data-cache miss/writeback path.
- Registers the winning request and drives the wrapper's requested/we/addr/wr_data handshake.
- Deasserts requested at the exact cycle the wrapper returns to ready, which prevents a spurious restart.
- Captures the 128-bit line and returns it to the owner as a one-cycle response pulse.
- Sits between the two caches and sram_wrapper, inside the core memory subsystem.

Parameters:
- ADDR_W, 20, memory word address width (matches wrapper addr_in).
- LINE_W, 128, cache line width in bits.

Ports:
- clk  in  1  core clock
- reset  in  1  asynchronous, active-high reset
- ic_req_valid  in  1  icache line fill request; held high until ic_resp_valid
- ic_req_addr  in  ADDR_W  icache line base address
- ic_resp_valid  out  1  one-cycle pulse; ic_resp_data valid
- ic_resp_data  out  LINE_W  returned line
- dc_req_valid  in  1  dcache request; held high until dc_resp_valid
- dc_req_we  in  1  1 = line writeback, 0 = line fill
- dc_req_addr  in  ADDR_W  dcache line base address
- dc_req_wdata  in  LINE_W  writeback data
- dc_resp_valid  out  1  one-cycle completion pulse (read and write)
- dc_resp_data  out  LINE_W  returned line (reads only; don't-care on writes)
- is_loading_memory_into_core  in  1  boot loader owns SRAM; blocks new grants
- mem_requested  out  1  to wrapper requested
- mem_we  out  1  to wrapper we
- mem_addr  out  ADDR_W  to wrapper addr_in
- mem_wr_data  out  LINE_W  to wrapper wr_data
- mem_reset_req  out  1  to wrapper reset_mem_req; one-cycle abort pulse
- mem_ready  in  1  from wrapper ready
- mem_rd_data  in  LINE_W  from wrapper rd_data_out
- busy  out  1  state != IDLE
- owner  out  1  0 = icache, 1 = dcache; valid while busy

Behaviour:
Reset:
- Asynchronous. state=IDLE; all outputs 0, including last_owner and the response data registers.

FSM states: IDLE, LAUNCH, WAIT, CAPTURE, RESP.

Transitions:
- IDLE:
  - Stays in IDLE while is_loading_memory_into_core=1 or mem_ready=0.
  - Otherwise, on any valid request, grants and registers owner, addr, we, wdata, then goes to LAUNCH.
  - An icache grant forces we=0.
- Arbitration:
  - Round-robin on internal last_owner.
  - If both valid, grant the requester that is not last_owner; a single valid wins outright.
  - last_owner updates at grant.
- LAUNCH:
  - mem_requested=1.
  - If mem_ready=1, go to WAIT next cycle (wrapper starts its countdown on this edge).
  - Otherwise stay in LAUNCH.
- WAIT:
  - mem_requested = ~mem_ready (combinational), held high through the countdown for the wrapper write path.
  - When mem_ready=1, go to CAPTURE; mem_requested is 0 that cycle.
- CAPTURE:
  - mem_requested=0; one-cycle settle for the wrapper's registered last read chunk.
  - Latch mem_rd_data into the owner's resp_data register.
  - Go to RESP.
- RESP:
  - Owner's resp_valid=1 for exactly one cycle.
  - Go to IDLE. A new grant is possible on the next cycle, not in the same cycle.

Outputs and data:
- mem_we, mem_addr and mem_wr_data come from the grant registers and are stable from LAUNCH through CAPTURE; they are 0 in IDLE.
- resp_data holds its value until the next capture for the same owner.

Abort:
- If the owner's req_valid drops in LAUNCH or WAIT: mem_reset_req=1 for one cycle, mem_requested=0, return to IDLE.
- No resp pulse; last_owner is unchanged from the grant.

Loader interaction:
- is_loading_memory_into_core rising mid-transaction does not abort; the transaction completes normally.
- Only new grants are blocked.

Simultaneous events:
- A request arriving in RESP is not granted until IDLE.
- Both requesters valid with last_owner=dcache: icache wins.

Width rules:
- Addresses pass through unmodified; the wrapper adds the word offset.

Test Plan:
- Single icache fill:
  - Stimulus: reset, then ic_req_valid=1, addr=0x00040.
  - Required: mem_requested high from LAUNCH until the cycle mem_ready returns; mem_we=0 throughout; exactly one wrapper countdown.
  - Required: ic_resp_valid pulses 2 cycles after mem_ready rises, ic_resp_data = preloaded line 0x33333333_22222222_11111111_00000000.
- Dcache writeback:
  - Stimulus: dc_req_we=1, addr=0x00100, wdata=0xDDDDDDDD_CCCCCCCC_BBBBBBBB_AAAAAAAA.
  - Required: words 0x100..0x103 written with AAAAAAAA, BBBBBBBB, CCCCCCCC, DDDDDDDD in order.
  - Required: dc_resp_valid pulses once; a later read of 0x00100 returns the same line.
- Contention and fairness:
  - Stimulus: both valid at the same cycle after reset (last_owner=0).
  - Required: dcache granted first (owner=1), icache second; each response pulses once, in that order.
- Abort:
  - Stimulus: drop dc_req_valid two cycles into WAIT.
  - Required: mem_reset_req one-cycle pulse; mem_ready=1 the next cycle; no dc_resp_valid; busy=0.
- Loader and reset:
  - Stimulus: is_loading_memory_into_core=1 with ic_req_valid=1.
  - Required: no grant while the loader is active; grant on the first cycle after it drops.
  - Stimulus: assert reset asynchronously mid-WAIT.
  - Required: all outputs 0 immediately, state IDLE.
